// File: rtl/imm_gen_pipe.sv
// Two-stage elastic immediate generator: S1 holds the raw instruction, S2 the formatted immediate.
// Define IMM_GEN_RVC_EN to make the compressed selects (CI, CIW) legal; otherwise they report err_out.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_in,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             err_out
);

    typedef enum logic [2:0] {
        SEL_I   = 3'd0,
        SEL_S   = 3'd1,
        SEL_B   = 3'd2,
        SEL_U   = 3'd3,
        SEL_J   = 3'd4,
        SEL_Z   = 3'd5,
        SEL_CI  = 3'd6,
        SEL_CIW = 3'd7
    } imm_sel_e;

    // Only the instruction bits some legal format reads are stored.
`ifdef IMM_GEN_RVC_EN
    localparam int INST_LO = 2;
`else
    localparam int INST_LO = 7;
`endif

    logic                s1_valid_q, s1_valid_d;
    logic [31:INST_LO]   s1_inst_q,  s1_inst_d;
    imm_sel_e            s1_sel_q,   s1_sel_d;
    logic [TAG_W-1:0]    s1_tag_q,   s1_tag_d;

    logic                s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]     s2_imm_q,   s2_imm_d;
    logic [TAG_W-1:0]    s2_tag_q,   s2_tag_d;
    logic                s2_err_q,   s2_err_d;

    logic                s2_load;
    logic [31:0]         fmt32;
    logic                fmt_err;

    always_comb begin
        fmt32   = '0;
        fmt_err = 1'b0;
        case (s1_sel_q)
            SEL_I: fmt32 = {{20{s1_inst_q[31]}}, s1_inst_q[31:20]};
            SEL_S: fmt32 = {{20{s1_inst_q[31]}}, s1_inst_q[31:25], s1_inst_q[11:7]};
            SEL_B: fmt32 = {{19{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[7],
                            s1_inst_q[30:25], s1_inst_q[11:8], 1'b0};
            SEL_U: fmt32 = {s1_inst_q[31:12], 12'b0};
            SEL_J: fmt32 = {{11{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[19:12],
                            s1_inst_q[20], s1_inst_q[30:21], 1'b0};
            SEL_Z: fmt32 = {27'b0, s1_inst_q[19:15]};
`ifdef IMM_GEN_RVC_EN
            SEL_CI:  fmt32 = {{26{s1_inst_q[12]}}, s1_inst_q[12], s1_inst_q[6:2]};
            SEL_CIW: fmt32 = {22'b0, s1_inst_q[10:7], s1_inst_q[12:11],
                              s1_inst_q[5], s1_inst_q[6], 2'b00};
`endif
            default: begin
                fmt32   = '0;
                fmt_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        s2_load  = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s2_load;

        s1_valid_d = s1_valid_q;
        s1_inst_d  = s1_inst_q;
        s1_sel_d   = s1_sel_q;
        s1_tag_d   = s1_tag_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            s1_inst_d = inst_in[31:INST_LO];
            s1_sel_d  = imm_sel_e'(imm_sel);
            s1_tag_d  = tag_in;
        end

        s2_valid_d = s2_valid_q;
        s2_imm_d   = s2_imm_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
        end
        if (s2_load && s1_valid_q) begin
            // Zero-extended fields never reach bit 31, so one signed widening covers every format.
            s2_imm_d = XLEN'($signed(fmt32));
            s2_tag_d = s1_tag_q;
            s2_err_d = fmt_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= '0;
            s1_sel_q   <= SEL_I;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_tag_q   <= '0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            s1_sel_q   <= s1_sel_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_imm_q   <= s2_imm_d;
            s2_tag_q   <= s2_tag_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign imm_out   = s2_imm_q;
    assign tag_out   = s2_tag_q;
    assign err_out   = s2_err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share the stimulus.
// Expected immediates come from an arithmetic model of the format rules (honours IMM_GEN_RVC_EN).
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst_in;
    logic [2:0]  imm_sel;
    logic [3:0]  tag_in;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [3:0]  tag32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [3:0]  tag64;

    exp_t q32[$];
    exp_t q64[$];
    bit   hold32, hold64;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .inst_in(inst_in), .imm_sel(imm_sel), .tag_in(tag_in),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_out(imm32), .tag_out(tag32), .err_out(err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .inst_in(inst_in), .imm_sel(imm_sel), .tag_in(tag_in),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_out(imm64), .tag_out(tag64), .err_out(err64)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sx(longint raw, int bits);
        if (raw[bits-1]) return raw - (longint'(1) << bits);
        return raw;
    endfunction

    function automatic exp_t model(logic [31:0] inst, logic [2:0] sel, logic [3:0] tag);
        exp_t   e;
        longint v;
        v     = 0;
        e.err = 1'b0;
        e.tag = tag;
        case (sel)
            3'd0: v = sx(longint'(inst[31:20]), 12);
            3'd1: v = sx(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12);
            3'd2: v = sx(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
                         + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
            3'd3: v = sx(longint'(inst[31:12]) * 4096, 32);
            3'd4: v = sx(longint'(inst[31]) * (1 << 20) + longint'(inst[19:12]) * (1 << 12)
                         + longint'(inst[20]) * (1 << 11) + longint'(inst[30:21]) * 2, 21);
            3'd5: v = longint'(inst[19:15]);
`ifdef IMM_GEN_RVC_EN
            3'd6: v = sx(longint'(inst[12]) * 32 + longint'(inst[6:2]), 6);
            3'd7: v = longint'(inst[10:7]) * 64 + longint'(inst[12:11]) * 16
                      + longint'(inst[5]) * 8 + longint'(inst[6]) * 4;
`endif
            default: begin
                v     = 0;
                e.err = 1'b1;
            end
        endcase
        e.imm = v;
        return e;
    endfunction

    task automatic check_port(string pfx, bit wide, logic ov, logic [63:0] imm,
                              logic [3:0] tag, logic err, ref exp_t q[$], ref bit hold);
        exp_t        e;
        logic [63:0] want;
        if (hold) chk({pfx, "_held_valid"}, ov, 1'b1);
        if (ov) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_output actual=0x%0h required=none", pfx, imm);
            end else begin
                e    = q[0];
                want = wide ? e.imm : {32'b0, e.imm[31:0]};
                chk({pfx, "_imm"}, imm, want);
                chk({pfx, "_tag"}, tag, e.tag);
                chk({pfx, "_err"}, err, e.err);
                if (out_ready) void'(q.pop_front());
            end
        end
        hold = ov && !out_ready;
    endtask

    // Monitor: compare outputs on the falling edge, then log inputs accepted at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold32 = 1'b0;
                hold64 = 1'b0;
            end else begin
                check_port("x32", 1'b0, out_valid32, {32'b0, imm32}, tag32, err32, q32, hold32);
                check_port("x64", 1'b1, out_valid64, imm64, tag64, err64, q64, hold64);
                if (in_valid && in_ready32) q32.push_back(model(inst_in, imm_sel, tag_in));
                if (in_valid && in_ready64) q64.push_back(model(inst_in, imm_sel, tag_in));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] inst, logic [2:0] sel, logic [3:0] tag);
        in_valid = v;
        inst_in  = inst;
        imm_sel  = sel;
        tag_in   = tag;
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 20 && (q32.size() != 0 || q64.size() != 0); i++) tick();
        chk({name, "_q32_empty"}, q32.size(), 0);
        chk({name, "_q64_empty"}, q64.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 4'h0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready32, 1'b1);
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_imm", imm32, 0);
        chk("rst_tag", tag32, 0);
        chk("rst_err", err32, 0);
        chk("rst_out_valid64", out_valid64, 1'b0);
        chk("rst_imm64", imm64, 0);
        tick();

        // I-type latency and value
        drive(1'b1, 32'hFFF00093, 3'd0, 4'd3);
        tick();
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        chk("lat_edge1_valid", out_valid32, 1'b0);
        tick();
        chk("lat_edge2_valid", out_valid32, 1'b1);
        chk("itype_imm", imm32, 32'hFFFFFFFF);
        chk("itype_tag", tag32, 4'd3);
        chk("itype_err", err32, 1'b0);
        tick();

        // B, U, J back to back, no bubbles
        drive(1'b1, 32'hFE000EE3, 3'd2, 4'd1);
        tick();
        drive(1'b1, 32'h123450B7, 3'd3, 4'd2);
        tick();
        chk("b2b_slot0_valid", out_valid32, 1'b1);
        chk("btype_imm", imm32, 32'hFFFFFFFC);
        drive(1'b1, 32'h0010006F, 3'd4, 4'd4);
        tick();
        chk("b2b_slot1_valid", out_valid32, 1'b1);
        chk("utype_imm", imm32, 32'h12345000);
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        tick();
        chk("b2b_slot2_valid", out_valid32, 1'b1);
        chk("jtype_imm", imm32, 32'h00000800);
        tick();
        chk("b2b_drained", out_valid32, 1'b0);

        // U-type sign extension on the 64-bit instance
        drive(1'b1, 32'h800000B7, 3'd3, 4'd8);
        tick();
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        tick();
        chk("x64_u_valid", out_valid64, 1'b1);
        chk("x64_u_imm", imm64, 64'hFFFFFFFF80000000);
        chk("x64_u_imm32", imm32, 32'h80000000);
        tick();

        // Compressed CI select
        drive(1'b1, 32'h0000107D, 3'd6, 4'd9);
        tick();
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        tick();
`ifdef IMM_GEN_RVC_EN
        chk("ci_imm", imm32, 32'hFFFFFFFF);
        chk("ci_err", err32, 1'b0);
`else
        chk("ci_imm", imm32, 0);
        chk("ci_err", err32, 1'b1);
`endif
        tick();

        // Backpressure: two held, third refused until the consumer accepts
        out_ready = 1'b0;
        drive(1'b1, 32'h00500093, 3'd0, 4'd5);
        tick();
        chk("bp_ready_after1", in_ready32, 1'b1);
        drive(1'b1, 32'h00600093, 3'd0, 4'd6);
        tick();
        drive(1'b1, 32'h00700093, 3'd0, 4'd7);
        for (int i = 0; i < 3; i++) begin
            chk("bp_full_in_ready", in_ready32, 1'b0);
            chk("bp_full_in_ready64", in_ready64, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready32, 1'b1);
        tick();
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        drain("bp_drain");

        // Reset while two entries are held
        out_ready = 1'b0;
        drive(1'b1, 32'h00A00093, 3'd0, 4'd10);
        tick();
        drive(1'b1, 32'h00B00093, 3'd0, 4'd11);
        tick();
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid32, 1'b0);
        chk("midrst_out_valid64", out_valid64, 1'b0);
        chk("midrst_imm", imm32, 0);
        chk("midrst_tag", tag32, 0);
        q32.delete();
        q64.delete();
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", in_ready32, 1'b1);
        drive(1'b1, 32'h00C00093, 3'd0, 4'd12);
        tick();
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        chk("postrst_no_stale", out_valid32, 1'b0);
        tick();
        chk("postrst_valid", out_valid32, 1'b1);
        chk("postrst_imm", imm32, 32'h0000000C);
        drain("postrst_drain");

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom, 3'($urandom % 8), 4'($urandom % 16));
            out_ready = (i % 50 < 20) ? 1'b1 : (($urandom % 3) != 0);
            tick();
        end
        drive(1'b0, 32'h0, 3'd0, 4'd0);
        out_ready = 1'b1;
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
